// File: rtl/ir_queue.sv
// ir_queue: instruction queue between fetch and decode.
// Circular buffer of DEPTH entries, each holding a 32-bit RV32I word and its PC.
// The head entry is presented with every RV32I field and immediate decoded
// combinationally; an empty queue presents all-zero head outputs.
module ir_queue #(
   parameter int DEPTH    = 4,
   parameter int PC_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_instr,
   input  logic [PC_WIDTH-1:0]          in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_instr,
   output logic [PC_WIDTH-1:0]          out_pc,
   output logic [6:0]                   opcode,
   output logic [2:0]                   funct3,
   output logic [6:0]                   funct7,
   output logic [4:0]                   rs1,
   output logic [4:0]                   rs2,
   output logic [4:0]                   rd,
   output logic [31:0]                  i_imm,
   output logic [31:0]                  s_imm,
   output logic [31:0]                  b_imm,
   output logic [31:0]                  u_imm,
   output logic [31:0]                  j_imm,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [31:0]         mem_instr [DEPTH];
   logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
   logic                push;
   logic                pop;
   logic [31:0]         head;
   logic [PC_WIDTH-1:0] head_pc;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // in_ready deliberately ignores out_ready: a full queue never accepts,
   // even on a cycle that also pops.
   assign in_ready  = (count < CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Queue control: reset beats flush, flush beats both handshakes.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so push and pop see a consistent count and pointers.
      if (!rst_n || flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; a push discarded by reset or flush is not stored.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; stale words are never visible
      // because the head mux forces zeros while the queue is empty.
      if (rst_n && !flush && push) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_pc[wr_ptr]    <= in_pc;
      end
   end

   // Head selection: zero when empty so every decoded field reads as zero.
   always_comb begin
      // NOTE: defaults first so no path through the block leaves a latch.
      head    = '0;
      head_pc = '0;
      if (out_valid) begin
         head    = mem_instr[rd_ptr];
         head_pc = mem_pc[rd_ptr];
      end
   end

   assign out_instr = head;
   assign out_pc    = head_pc;
   assign opcode    = head[6:0];
   assign funct3    = head[14:12];
   assign funct7    = head[31:25];
   assign rs1       = head[19:15];
   assign rs2       = head[24:20];
   assign rd        = head[11:7];
   assign i_imm     = {{21{head[31]}}, head[30:20]};
   assign s_imm     = {{21{head[31]}}, head[30:25], head[11:7]};
   assign b_imm     = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
   assign u_imm     = {head[31:12], 12'h000};
   assign j_imm     = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: self-checking bench for ir_queue (DEPTH=4, PC_WIDTH=32).
// A queue-based reference model tracks contents; immediates are recomputed
// with signed arithmetic from the instruction bit fields.
module tb_ir_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_instr, out_pc;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   logic [31:0] mq_instr[$];
   logic [31:0] mq_pc[$];

   ir_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .u_imm(u_imm), .j_imm(j_imm),
      .count(count)
   );

   always #5 clk = ~clk;

   // Expected head bundle, built from field positions and signed arithmetic.
   function automatic logic [255:0] exp_head(input logic v, input logic [31:0] h, input logic [31:0] pc);
      int ii, si, bi, ui, ji;
      if (!v) return '0;
      ii = (h[31] ? -2048 : 0) + int'(h[30:20]);
      si = (h[31] ? -2048 : 0) + int'(h[30:25]) * 32 + int'(h[11:7]);
      bi = (h[31] ? -4096 : 0) + int'(h[7]) * 2048 + int'(h[30:25]) * 32 + int'(h[11:8]) * 2;
      ui = int'(h & 32'hFFFF_F000);
      ji = (h[31] ? -(1 << 20) : 0) + int'(h[19:12]) * 4096 + int'(h[20]) * 2048 + int'(h[30:21]) * 2;
      return {h, pc, h[6:0], h[14:12], h[31:25], h[19:15], h[24:20], h[11:7],
              32'(ii), 32'(si), 32'(bi), 32'(ui), 32'(ji)};
   endfunction

   function automatic logic [255:0] dut_head();
      return {out_instr, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
              i_imm, s_imm, b_imm, u_imm, j_imm};
   endfunction

   function automatic logic [255:0] model_head();
      if (mq_instr.size() == 0) return '0;
      return exp_head(1'b1, mq_instr[0], mq_pc[0]);
   endfunction

   // Apply one cycle of inputs, advance the model, then step past the edge.
   task automatic tick(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rn);
      logic do_push, do_pop;
      in_valid  = iv;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst_n     = rn;
      if (!rn || fl) begin
         mq_instr.delete();
         mq_pc.delete();
      end else begin
         do_push = iv && (mq_instr.size() < DEPTH);
         do_pop  = ordy && (mq_instr.size() != 0);
         if (do_pop) begin
            void'(mq_instr.pop_front());
            void'(mq_pc.pop_front());
         end
         if (do_push) begin
            mq_instr.push_back(ins);
            mq_pc.push_back(pc);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: count=%0d out_valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
      end
      checks++;
      if (dut_head() !== '0) begin
         errors++;
         $display("FAIL reset_head: got %h want 0", dut_head());
      end
   endtask

   task automatic test_addi();
      tick(1'b1, 32'h00A0_0093, 32'h100, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || opcode !== 7'h13 || rd !== 5'd1 || rs1 !== 5'd0 ||
          funct3 !== 3'd0 || i_imm !== 32'h0000_000A || out_pc !== 32'h100) begin
         errors++;
         $display("FAIL addi_decode: v=%b op=%h rd=%0d rs1=%0d f3=%0d imm=%h pc=%h want 1/13/1/0/0/0000000a/100",
                  out_valid, opcode, rd, rs1, funct3, i_imm, out_pc);
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL addi_drain: out_valid=%b count=%0d want 0/0", out_valid, count);
      end
   endtask

   task automatic test_fill_drain();
      logic [31:0] words[DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         words[i] = $urandom;
         tick(1'b1, words[i], 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
         checks++;
         if (count !== 3'(i + 1)) begin
            errors++;
            $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
         end
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: got %b want 0", in_ready);
      end
      tick(1'b1, 32'hDEAD_BEEF, 32'hFFF0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (count !== 3'd4 || out_instr !== words[0]) begin
         errors++;
         $display("FAIL full_ignore: count=%0d head=%h want 4/%h", count, out_instr, words[0]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (out_instr !== words[i] || out_pc !== 32'h200 + 32'(4 * i)) begin
            errors++;
            $display("FAIL drain_order[%0d]: got %h@%h want %h@%h", i, out_instr, out_pc,
                     words[i], 32'h200 + 32'(4 * i));
         end
         tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      end
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: count=%0d out_valid=%b want 0/0", count, out_valid);
      end
   endtask

   task automatic test_stream();
      tick(1'b1, $urandom, 32'h1000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, $urandom, 32'h1004 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
         checks++;
         if (count !== 3'd1 || dut_head() !== model_head()) begin
            errors++;
            $display("FAIL stream[%0d]: count=%0d head=%h want 1/%h", i, count, dut_head(), model_head());
         end
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_imm();
      tick(1'b1, 32'hFE00_0FE3, 32'h300, 1'b0, 1'b0, 1'b1);
      checks++;
      if (b_imm !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL b_imm: got %h want fffffffe", b_imm);
      end
      tick(1'b1, 32'h8000_00EF, 32'h304, 1'b1, 1'b0, 1'b1);
      checks++;
      if (j_imm !== 32'hFFF0_0000 || rd !== 5'd1) begin
         errors++;
         $display("FAIL j_imm: got %h rd=%0d want fff00000 rd=1", j_imm, rd);
      end
      tick(1'b1, 32'hABCD_E0B7, 32'h308, 1'b1, 1'b0, 1'b1);
      checks++;
      if (u_imm !== 32'hABCD_E000) begin
         errors++;
         $display("FAIL u_imm: got %h want abcde000", u_imm);
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
      tick(1'b1, 32'h1234_5678, 32'h40C, 1'b0, 1'b1, 1'b1);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || dut_head() !== '0) begin
         errors++;
         $display("FAIL flush: count=%0d v=%b rdy=%b head=%h want 0/0/1/0", count, out_valid, in_ready, dut_head());
      end
      tick(1'b1, 32'h0010_0113, 32'h500, 1'b0, 1'b0, 1'b1);
      checks++;
      if (count !== 3'd1 || out_instr !== 32'h0010_0113 || out_pc !== 32'h500) begin
         errors++;
         $display("FAIL flush_after: count=%0d head=%h@%h want 1/00100113@500", count, out_instr, out_pc);
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) tick(1'b1, $urandom, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
      tick(1'b1, 32'hCAFE_0013, 32'h608, 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: count=%0d rdy=%b v=%b want 0/1/0", count, in_ready, out_valid);
      end
      tick(1'b1, 32'h0020_0193, 32'h700, 1'b0, 1'b0, 1'b1);
      checks++;
      if (count !== 3'd1 || dut_head() !== exp_head(1'b1, 32'h0020_0193, 32'h700)) begin
         errors++;
         $display("FAIL reset_mid_push: count=%0d head=%h want 1/%h", count, dut_head(),
                  exp_head(1'b1, 32'h0020_0193, 32'h700));
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) != 0));
         checks++;
         if (count !== 3'(mq_instr.size()) || in_ready !== (mq_instr.size() < DEPTH) ||
             out_valid !== (mq_instr.size() != 0) || dut_head() !== model_head()) begin
            errors++;
            $display("FAIL random[%0d]: count=%0d head=%h want count=%0d head=%h", i, count,
                     dut_head(), mq_instr.size(), model_head());
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      test_reset();
      test_addi();
      test_fill_drain();
      test_stream();
      test_imm();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
